// File: rtl/sram_sim_model.sv
`default_nettype none
// ============================================================================
// Module   : sram_sim_model
// Brief    : Clocked model of an asynchronous 16-bit SRAM with byte lanes,
//            programmable read wait states, range checking and a write count.
// Revision : 1.0 - initial release
// ============================================================================
module sram_sim_model #(
    parameter int unsigned DEPTH_LOG2 = 6,
    parameter int unsigned ADDR_W     = 20,
    parameter int unsigned RD_LAT     = 0,
    parameter logic [15:0] INIT0      = 16'h0000
) (
    input  logic              Clk,
    input  logic              Reset,
    inout  wire  [15:0]       I_O,
    input  logic [ADDR_W-1:0] A,
    input  logic              CE,
    input  logic              OE,
    input  logic              WE,
    input  logic              UB,
    input  logic              LB,
    output logic              Rd_Valid,
    output logic              Oor_Err,
    input  logic              Clr_Err,
    output logic [15:0]       Wr_Cnt
);

    localparam int         DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [2:0] c_RD_LAT = 3'(RD_LAT);

    logic [15:0]           mem_q [DEPTH];
    logic [2:0]            wait_q;
    logic [2:0]            wait_d;
    logic [2:0]            wait_eff;
    logic [ADDR_W-1:0]     prev_a_q;
    logic                  oor_q;
    logic                  oor_d;
    logic [15:0]           cnt_q;
    logic [15:0]           cnt_d;

    logic                  in_range;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  wr_cycle;
    logic                  wr_commit;
    logic                  rd_req;
    logic                  addr_same;
    logic                  oor_set;
    logic [15:0]           rd_word;

    assign word_idx = A[DEPTH_LOG2-1:0];

    generate
        if (ADDR_W > DEPTH_LOG2) begin : g_range_chk
            assign in_range = (A[ADDR_W-1:DEPTH_LOG2] == '0);
        end else begin : g_range_full
            assign in_range = 1'b1;
        end
    endgenerate

    // The effective wait count drops to zero in the very cycle the address
    // moves, so stale data from the old address is never flagged valid.
    always_comb begin
        wr_cycle  = ~CE & ~WE;
        wr_commit = wr_cycle & in_range & ~(UB & LB);
        rd_req    = ~CE & ~OE & WE;
        addr_same = (A == prev_a_q);
        wait_eff  = (rd_req && addr_same) ? wait_q : 3'd0;
        Rd_Valid  = rd_req & (wait_eff == c_RD_LAT) & ~Reset;
        rd_word   = in_range ? mem_q[word_idx] : 16'h0000;
        oor_set   = ~in_range & (wr_cycle | (rd_req & Rd_Valid));
    end

    always_comb begin
        wait_d = 3'd0;
        if (rd_req && addr_same) begin
            wait_d = (wait_q >= c_RD_LAT) ? c_RD_LAT : wait_q + 3'd1;
        end
        oor_d = oor_q;
        if (oor_set) begin
            oor_d = 1'b1;
        end else if (Clr_Err) begin
            oor_d = 1'b0;
        end
        cnt_d = cnt_q + 16'(wr_commit);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_q <= 3'd0;
            oor_q  <= 1'b0;
            cnt_q  <= 16'h0000;
        end else begin
            wait_q <= wait_d;
            oor_q  <= oor_d;
            cnt_q  <= cnt_d;
        end
    end

    // Previous address tracks the pins even through reset.
    always_ff @(posedge Clk) begin
        prev_a_q <= A;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= (i == 0) ? INIT0 : 16'h0000;
            end
        end else if (wr_commit) begin
            if (!UB) begin
                mem_q[word_idx][15:8] <= I_O[15:8];
            end
            if (!LB) begin
                mem_q[word_idx][7:0] <= I_O[7:0];
            end
        end
    end

    assign I_O[15:8] = (Rd_Valid && !UB) ? rd_word[15:8] : 8'hzz;
    assign I_O[7:0]  = (Rd_Valid && !LB) ? rd_word[7:0]  : 8'hzz;

    assign Oor_Err = oor_q;
    assign Wr_Cnt  = cnt_q;

endmodule
`default_nettype wire
